// File: rtl/control_seq_if.sv
// rtl/control_seq_if.sv - control sequencer bus: instruction fetch, data memory handshake, control strobes
// Purpose: bundles every control_seq signal except clk/reset.
// Ports (master = sequencer side):
//   in : init, instr[IW], instr_valid, mem_ack
//   out: fetch_req, mem_req, mem_we, reg_write, mem_to_reg, branch,
//        op[3], page[PAGE_W], page_err, mem_err, busy
interface control_seq_if #(
  parameter int IW     = 9,
  parameter int PAGE_W = 2
);
  logic              init;
  logic [IW-1:0]     instr;
  logic              instr_valid;
  logic              mem_ack;
  logic              fetch_req;
  logic              mem_req;
  logic              mem_we;
  logic              reg_write;
  logic              mem_to_reg;
  logic              branch;
  logic [2:0]        op;
  logic [PAGE_W-1:0] page;
  logic              page_err;
  logic              mem_err;
  logic              busy;

  modport master (
    input  init, instr, instr_valid, mem_ack,
    output fetch_req, mem_req, mem_we, reg_write, mem_to_reg, branch,
           op, page, page_err, mem_err, busy
  );

  modport slave (
    output init, instr, instr_valid, mem_ack,
    input  fetch_req, mem_req, mem_we, reg_write, mem_to_reg, branch,
           op, page, page_err, mem_err, busy
  );
endinterface

// File: rtl/control_seq.sv
// rtl/control_seq.sv - Moore control sequencer with page register and memory timeout
// Purpose: sequences FETCH/EXEC/MEM/WB for a small IW-bit instruction set,
//   keeps a saturating page register and sticky page/memory error flags.
// Ports:
//   clk   in  clock, all state on rising edge
//   reset in  synchronous active-high reset, highest priority
//   bus   control_seq_if.master (see interface for signal list)
// Opcode map (instr[IW-1:IW-3]): 0 AND, 1 XOR, 2 SHL, 3 SHR, 4 ADD, 5 LW, 6 SW, 7 BR.
// The page words share opcode 1 and are recognised as full words first.
module control_seq #(
  parameter int            IW      = 9,
  parameter int            PAGE_W  = 2,
  parameter logic [IW-1:0] INC_ENC = 9'b001111000,
  parameter logic [IW-1:0] DEC_ENC = 9'b001110000,
  parameter int            MEM_TO  = 8
) (
  input logic          clk,
  input logic          reset,
  control_seq_if.master bus
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_XOR = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_LW  = 3'd5;
  localparam logic [2:0] OP_SW  = 3'd6;
  localparam logic [2:0] OP_BR  = 3'd7;

  localparam int                CW       = $clog2(MEM_TO + 1);
  localparam logic [CW-1:0]     WAIT_MAX = CW'(MEM_TO - 1);
  localparam logic [PAGE_W-1:0] PAGE_MAX = {PAGE_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     ir;
  logic [PAGE_W-1:0] page;
  logic              page_err, mem_err;
  logic [CW-1:0]     wcnt;

  logic [2:0] op;
  logic       is_inc, is_dec, timeout;
  logic       fetch_req, mem_req, mem_we, reg_write, mem_to_reg, branch;

  assign op      = ir[IW-1:IW-3];
  assign is_inc  = (ir == INC_ENC);
  assign is_dec  = (ir == DEC_ENC);
  // The cycle that would take the no-ack count to MEM_TO is the last one.
  assign timeout = (wcnt == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fetch_req  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (bus.instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (is_inc || is_dec) begin
          state_nxt = FETCH;
        end else begin
          case (op)
            OP_AND, OP_XOR, OP_SHL, OP_SHR, OP_ADD: state_nxt = WB;
            OP_LW, OP_SW:                           state_nxt = MEM;
            OP_BR: begin
              branch    = 1'b1;
              state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
          endcase
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_SW);
        // An ack in the timeout cycle still completes the access normally.
        if (bus.mem_ack) begin
          state_nxt = (op == OP_LW) ? WB : FETCH;
        end else if (timeout) begin
          state_nxt = FETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op == OP_LW);
        state_nxt  = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.init) state_nxt = IDLE;
  end

  // Datapath side effects are suppressed while init is high so an abort
  // leaves page and error flags exactly as they were.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir       <= '0;
      page     <= '0;
      page_err <= 1'b0;
      mem_err  <= 1'b0;
      wcnt     <= '0;
    end else if (!bus.init) begin
      case (state)
        FETCH: begin
          if (bus.instr_valid) ir <= bus.instr;
        end
        EXEC: begin
          wcnt <= '0;
          if (is_inc) begin
            if (page == PAGE_MAX) page_err <= 1'b1;
            else                  page     <= page + 1'b1;
          end else if (is_dec) begin
            if (page == '0) page_err <= 1'b1;
            else            page     <= page - 1'b1;
          end
        end
        MEM: begin
          if (!bus.mem_ack) begin
            wcnt <= wcnt + 1'b1;
            if (timeout) mem_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fetch_req  = fetch_req;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.reg_write  = reg_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.branch     = branch;
  assign bus.op         = op;
  assign bus.page       = page;
  assign bus.page_err   = page_err;
  assign bus.mem_err    = mem_err;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - self-checking bench for control_seq, directed plus random programs
module tb_control_seq;
  localparam int IW     = 9;
  localparam int PAGE_W = 2;
  localparam int MEM_TO = 8;
  localparam logic [IW-1:0] INC_W = 9'b001111000;
  localparam logic [IW-1:0] DEC_W = 9'b001110000;
  localparam logic [2:0] O_LW = 3'd5, O_SW = 3'd6, O_BR = 3'd7;
  localparam int PAGE_TOP = (1 << PAGE_W) - 1;

  logic clk = 1'b0;
  logic reset;

  control_seq_if #(.IW(IW), .PAGE_W(PAGE_W)) bus ();

  control_seq #(
    .IW(IW), .PAGE_W(PAGE_W), .INC_ENC(INC_W), .DEC_ENC(DEC_W), .MEM_TO(MEM_TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int page_m = 0;
  int page_err_m = 0;
  int mem_err_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags();
    chk("page", 32'(bus.page), page_m);
    chk("page_err", 32'(bus.page_err), page_err_m);
    chk("mem_err", 32'(bus.mem_err), mem_err_m);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (bus.fetch_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", 32'(bus.fetch_req), 1);
    chk("busy", 32'(bus.busy), 1);
    check_flags();
  endtask

  // d: cycle index within MEM at which mem_ack is given (>= MEM_TO: never).
  // abort_at: MEM cycle in which init is raised (-1: no abort).
  task automatic run_instr(input logic [IW-1:0] word, input int d, input int abort_at);
    logic [2:0] opc;
    bit is_page, is_alu, is_mem, is_lw;
    opc     = word[IW-1:IW-3];
    is_page = (word == INC_W) || (word == DEC_W);
    is_alu  = !is_page && (opc inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    is_mem  = !is_page && (opc == O_LW || opc == O_SW);
    is_lw   = (opc == O_LW);

    wait_fetch();
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("fetch_hold", 32'(bus.fetch_req), 1);
    end
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = IW'($urandom);

    chk("exec_op", 32'(bus.op), 32'(opc));
    chk("exec_branch", 32'(bus.branch), (!is_page && opc == O_BR) ? 1 : 0);
    chk("exec_mem_req", 32'(bus.mem_req), 0);
    chk("exec_reg_write", 32'(bus.reg_write), 0);

    if (is_page) begin
      if (word == INC_W) begin
        if (page_m == PAGE_TOP) page_err_m = 1;
        else                    page_m++;
      end else begin
        if (page_m == 0) page_err_m = 1;
        else             page_m--;
      end
      @(negedge clk);
      chk("page_fetch", 32'(bus.fetch_req), 1);
      check_flags();
    end else if (is_alu) begin
      @(negedge clk);
      chk("wb_reg_write", 32'(bus.reg_write), 1);
      chk("wb_mem_to_reg", 32'(bus.mem_to_reg), 0);
      @(negedge clk);
      chk("alu_fetch", 32'(bus.fetch_req), 1);
      chk("alu_reg_write_off", 32'(bus.reg_write), 0);
    end else if (is_mem) begin
      for (int c = 0; c < MEM_TO; c++) begin
        @(negedge clk);
        chk("mem_req", 32'(bus.mem_req), 1);
        chk("mem_we", 32'(bus.mem_we), is_lw ? 0 : 1);
        chk("mem_reg_write", 32'(bus.reg_write), 0);
        if (c == abort_at) begin
          bus.init = 1'b1;
          @(negedge clk);
          bus.init = 1'b0;
          chk("abort_busy", 32'(bus.busy), 0);
          chk("abort_mem_req", 32'(bus.mem_req), 0);
          chk("abort_reg_write", 32'(bus.reg_write), 0);
          check_flags();
          break;
        end
        if (c == d) begin
          bus.mem_ack = 1'b1;
          @(negedge clk);
          bus.mem_ack = 1'b0;
          chk("ack_mem_req", 32'(bus.mem_req), 0);
          if (is_lw) begin
            chk("lw_reg_write", 32'(bus.reg_write), 1);
            chk("lw_mem_to_reg", 32'(bus.mem_to_reg), 1);
            @(negedge clk);
          end
          chk("ack_fetch", 32'(bus.fetch_req), 1);
          chk("ack_reg_write_off", 32'(bus.reg_write), 0);
          check_flags();
          break;
        end
        if (c == MEM_TO - 1) begin
          mem_err_m = 1;
          @(negedge clk);
          chk("to_fetch", 32'(bus.fetch_req), 1);
          chk("to_reg_write", 32'(bus.reg_write), 0);
          check_flags();
        end
      end
    end else begin
      @(negedge clk);
      chk("br_branch_off", 32'(bus.branch), 0);
      chk("br_fetch", 32'(bus.fetch_req), 1);
      chk("br_reg_write", 32'(bus.reg_write), 0);
    end
  endtask

  task automatic hold_init(input int cycles);
    bus.init = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      chk("init_idle", 32'(bus.busy), 0);
      chk("init_fetch_off", 32'(bus.fetch_req), 0);
    end
    bus.init = 1'b0;
    check_flags();
  endtask

  initial begin
    logic [IW-1:0] w;
    int r;
    reset           = 1'b1;
    bus.init        = 1'b0;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_op", 32'(bus.op), 0);
    chk("rst_fetch", 32'(bus.fetch_req), 0);
    check_flags();
    reset = 1'b0;

    run_instr(9'b100_000101, 0, -1);          // ADD
    run_instr(9'b101_000011, 2, -1);          // LW, ack on 3rd MEM cycle
    repeat (4) run_instr(INC_W, 0, -1);       // page 1,2,3,3 + page_err
    run_instr(DEC_W, 0, -1);                  // page 2, page_err stays
    run_instr(9'b110_000000, 1000, -1);       // SW, timeout
    run_instr(9'b101_111000, 1000, 1);        // LW aborted in 2nd MEM cycle
    run_instr(9'b111_010101, 0, -1);          // BR
    run_instr(9'b101_000001, MEM_TO - 1, -1); // ack in the timeout cycle wins

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 15);
      if (r < 3)      w = INC_W;
      else if (r < 5) w = DEC_W;
      else            w = IW'($urandom);
      run_instr(w, $urandom_range(0, MEM_TO + 1),
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, MEM_TO - 1) : -1);
      if ($urandom_range(0, 9) == 0) begin
        wait_fetch();
        hold_init($urandom_range(1, 3));
      end
    end

    @(negedge clk);
    reset           = 1'b1;
    bus.init        = 1'b1;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    page_m = 0; page_err_m = 0; mem_err_m = 0;
    chk("rst2_busy", 32'(bus.busy), 0);
    chk("rst2_op", 32'(bus.op), 0);
    check_flags();
    reset           = 1'b0;
    bus.init        = 1'b0;
    bus.instr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
